// File: rtl/rv32i_pkg.sv
// Shared RV32I ALU constants and the operation-select encoding.
package rv32i_pkg;

  localparam int OPERANDS_WIDTH = 32;
  localparam int ALU_SEL_WIDTH  = 4;
  localparam int SHAMT_WIDTH    = 5;

  typedef enum logic [ALU_SEL_WIDTH-1:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational log-stage barrel shifter for SLL, SRL and SRA.
module alu_shifter #(
  parameter int W   = 32,
  parameter int SHW = 5
) (
  input  logic [W-1:0]   data,
  input  logic [SHW-1:0] amount,
  input  logic           right,
  input  logic           arith,
  output logic [W-1:0]   shifted
);

  logic [W-1:0] stage [0:SHW];
  logic         fill;

  // Right shifts fill with the original sign bit only when arithmetic.
  assign fill     = arith & data[W-1];
  assign stage[0] = data;

  for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
    localparam int STEP = 1 << gi;
    logic [W-1:0] moved;

    always_comb begin
      if (right) begin
        moved = {{STEP{fill}}, stage[gi][W-1:STEP]};
      end else begin
        moved = {stage[gi][W-1-STEP:0], {STEP{1'b0}}};
      end
    end

    assign stage[gi+1] = amount[gi] ? moved : stage[gi];
  end

  assign shifted = stage[SHW];

endmodule

// File: rtl/rv32i_alu.sv
// Registered RV32I execute-stage ALU with one cycle of latency.
// Optional registered zero flag is built when ALU_ZERO_FLAG_EN is defined.
module rv32i_alu #(
  parameter int OPERANDS_WIDTH = rv32i_pkg::OPERANDS_WIDTH,
  parameter int ALU_SEL_WIDTH  = rv32i_pkg::ALU_SEL_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [OPERANDS_WIDTH-1:0] A,
  input  logic [OPERANDS_WIDTH-1:0] B,
  input  logic [ALU_SEL_WIDTH-1:0]  ALUSel,
  output logic [OPERANDS_WIDTH-1:0] result
`ifdef ALU_ZERO_FLAG_EN
  ,
  output logic                      zero
`endif
);

  import rv32i_pkg::*;

  localparam int W   = OPERANDS_WIDTH;
  localparam int SHW = $clog2(OPERANDS_WIDTH);

  alu_op_t       op;
  logic          sub_en;
  logic [W-1:0]  b_operand;
  logic [W:0]    sum_ext;
  logic          slt_bit;
  logic          sltu_bit;
  logic          shift_right;
  logic          shift_arith;
  logic [W-1:0]  shift_out;
  logic [W-1:0]  result_next;
  logic [W-1:0]  result_reg;

  assign op = alu_op_t'(ALUSel);

  // One adder serves ADD, SUB and both compares via A + ~B + 1.
  assign sub_en    = (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
  assign b_operand = sub_en ? ~B : B;
  assign sum_ext   = {1'b0, A} + {1'b0, b_operand} + {{W{1'b0}}, sub_en};

  // No carry out of A - B means a borrow, i.e. A < B unsigned.
  assign sltu_bit = ~sum_ext[W];
  assign slt_bit  = (A[W-1] != B[W-1]) ? A[W-1] : sum_ext[W-1];

  assign shift_right = (op == ALU_SRL) || (op == ALU_SRA);
  assign shift_arith = (op == ALU_SRA);

  alu_shifter #(
    .W   (W),
    .SHW (SHW)
  ) u_shifter (
    .data    (A),
    .amount  (B[SHW-1:0]),
    .right   (shift_right),
    .arith   (shift_arith),
    .shifted (shift_out)
  );

  always_comb begin
    result_next = '0;
    case (op)
      ALU_ADD,
      ALU_SUB:   result_next = sum_ext[W-1:0];
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:   result_next = shift_out;
      ALU_SLT:   result_next = {{(W-1){1'b0}}, slt_bit};
      ALU_SLTU:  result_next = {{(W-1){1'b0}}, sltu_bit};
      ALU_XOR:   result_next = A ^ B;
      ALU_OR:    result_next = A | B;
      ALU_AND:   result_next = A & B;
      ALU_PASSB: result_next = B;
      default:   result_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= '0;
    end else begin
      result_reg <= result_next;
    end
  end

  assign result = result_reg;

`ifdef ALU_ZERO_FLAG_EN
  logic zero_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_reg <= 1'b1;
    end else begin
      zero_reg <= (result_next == '0);
    end
  end

  assign zero = zero_reg;
`endif

endmodule

// File: tb/tb_rv32i_alu.sv
// Scoreboard bench for rv32i_alu: directed vectors with hand-computed results.
module tb_rv32i_alu;

  import rv32i_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUSel;
  logic [31:0] result;
`ifdef ALU_ZERO_FLAG_EN
  logic        zero;
`endif

  exp_t sb[$];
  int   checks;
  int   errors;

  rv32i_alu #(
    .OPERANDS_WIDTH (32),
    .ALU_SEL_WIDTH  (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .ALUSel (ALUSel),
    .result (result)
`ifdef ALU_ZERO_FLAG_EN
    ,
    .zero   (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end else begin
      $display("ok   %s: got %h", tag, act);
    end
  endtask

  // Monitor: every falling edge, compare the result registered at the previous rising edge.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.tag, result, e.exp);
`ifdef ALU_ZERO_FLAG_EN
        check({e.tag, "_zero"}, {31'b0, zero}, {31'b0, (e.exp == 32'h0)});
`endif
      end
    end
  endtask

  task automatic issue(string tag, logic [31:0] a, logic [31:0] b, logic [3:0] sel,
                       logic [31:0] exp);
    @(negedge clk);
    A      = a;
    B      = b;
    ALUSel = sel;
    @(posedge clk);
    sb.push_back('{tag: tag, exp: exp});
    // Scramble inputs between edges; the registered result must not move.
    #1;
    A      = $urandom;
    B      = $urandom;
    ALUSel = 4'($urandom_range(0, 15));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    A      = 32'h1234_5678;
    B      = 32'h9ABC_DEF0;
    ALUSel = 4'(ALU_ADD);
    fork
      monitor();
    join_none

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("reset_async", result, 32'h0);
`ifdef ALU_ZERO_FLAG_EN
    check("reset_async_zero", {31'b0, zero}, 32'h1);
`endif
    @(posedge clk);
    @(negedge clk);
    check("reset_hold", result, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Arithmetic
    issue("add_0_5",       32'h0000_0000, 32'h0000_0005, 4'(ALU_ADD),  32'h0000_0005);
    issue("sub_40_m50",    32'd40,        32'hFFFF_FFCE, 4'(ALU_SUB),  32'h0000_005A);
    issue("add_overflow",  32'h7FFF_FFFF, 32'h0000_0001, 4'(ALU_ADD),  32'h8000_0000);
    issue("sub_0_1",       32'h0000_0000, 32'h0000_0001, 4'(ALU_SUB),  32'hFFFF_FFFF);
    issue("sub_5_7",       32'd5,         32'd7,         4'(ALU_SUB),  32'hFFFF_FFFE);
    issue("sub_eq",        32'hCAFE_F00D, 32'hCAFE_F00D, 4'(ALU_SUB),  32'h0000_0000);
    // Compares
    issue("slt_m5_10",     32'hFFFF_FFFB, 32'd10,        4'(ALU_SLT),  32'h1);
    issue("sltu_m5_10",    32'hFFFF_FFFB, 32'd10,        4'(ALU_SLTU), 32'h0);
    issue("slt_eq",        32'd7,         32'd7,         4'(ALU_SLT),  32'h0);
    issue("sltu_eq",       32'd7,         32'd7,         4'(ALU_SLTU), 32'h0);
    issue("slt_minneg",    32'h8000_0000, 32'h0000_0000, 4'(ALU_SLT),  32'h1);
    issue("sltu_minneg",   32'h8000_0000, 32'h0000_0000, 4'(ALU_SLTU), 32'h0);
    issue("sltu_1_max",    32'h0000_0001, 32'hFFFF_FFFF, 4'(ALU_SLTU), 32'h1);
    issue("slt_1_m1",      32'h0000_0001, 32'hFFFF_FFFF, 4'(ALU_SLT),  32'h0);
    // Shifts
    issue("sra_m4_1",      32'hFFFF_FFFC, 32'd1,         4'(ALU_SRA),  32'hFFFF_FFFE);
    issue("srl_msb_31",    32'h8000_0000, 32'd31,        4'(ALU_SRL),  32'h0000_0001);
    issue("sra_msb_31",    32'h8000_0000, 32'd31,        4'(ALU_SRA),  32'hFFFF_FFFF);
    issue("sll_1_0x25",    32'h0000_0001, 32'h0000_0025, 4'(ALU_SLL),  32'h0000_0020);
    issue("sll_amt0",      32'h1234_5678, 32'h0000_0020, 4'(ALU_SLL),  32'h1234_5678);
    issue("srl_f0_4",      32'hF000_0000, 32'd4,         4'(ALU_SRL),  32'h0F00_0000);
    issue("sra_pos_4",     32'h7000_0000, 32'd4,         4'(ALU_SRA),  32'h0700_0000);
    issue("sll_1_31",      32'h0000_0001, 32'd31,        4'(ALU_SLL),  32'h8000_0000);
    // Logic, PASSB and unused codes
    issue("xor",           32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'(ALU_XOR),  32'hFF00_FF00);
    issue("or",            32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'(ALU_OR),   32'hFFF0_FFF0);
    issue("and",           32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'(ALU_AND),  32'h00F0_00F0);
    issue("passb",         32'h1111_1111, 32'hDEAD_BEEF, 4'(ALU_PASSB), 32'hDEAD_BEEF);
    issue("sel_11",        32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd11,        32'h0);
    issue("sel_13",        32'hFFFF_FFFF, 32'h0000_0001, 4'd13,        32'h0);
    issue("sel_15",        32'h8000_0000, 32'h8000_0000, 4'd15,        32'h0);
    issue("add_before_rst", 32'hAAAA_0000, 32'h0000_5555, 4'(ALU_ADD), 32'hAAAA_5555);

    // Mid-stream reset: result clears before the next rising edge.
    @(negedge clk);
    #1;
    rst_n  = 1'b0;
    A      = 32'd100;
    B      = 32'd200;
    ALUSel = 4'(ALU_ADD);
    #1;
    check("reset_midstream", result, 32'h0);
`ifdef ALU_ZERO_FLAG_EN
    check("reset_midstream_zero", {31'b0, zero}, 32'h1);
`endif
    @(negedge clk);
    check("reset_inflight_dropped", result, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue("after_release", 32'd100, 32'd200, 4'(ALU_ADD), 32'd300);
    issue("after_release2", 32'd9, 32'd3, 4'(ALU_SUB), 32'd6);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_alu.md
# rv32i_alu

Registered arithmetic/logic unit for the RV32I execute stage. It takes two operands and an operation select, and computes one RV32I integer operation: add, sub, shifts, compares or bitwise logic. The result is registered on the rising clock edge and feeds the memory/write-back path. Operand A comes from rs1/PC; operand B comes from rs2/immediate.

## Interface
Parameters:
- `OPERANDS_WIDTH`, default 32: operand and result width.
- `ALU_SEL_WIDTH`, default 4: operation-select width.

Ports:
- `clk` input, 1 bit: the single clock, rising-edge active.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `A` input, `OPERANDS_WIDTH` bits: operand A.
- `B` input, `OPERANDS_WIDTH` bits: operand B, also the shift-amount source.
- `ALUSel` input, `ALU_SEL_WIDTH` bits: operation select.
- `result` output, `OPERANDS_WIDTH` bits: registered operation result.
- `zero` output, 1 bit: present only with `ALU_ZERO_FLAG_EN`.

## Operation
`ALUSel` encoding:
- 0 ADD: A+B, modulo 2^W, carry discarded.
- 1 SUB: A−B, modulo 2^W.
- 2 SLL: A << B[4:0].
- 3 SLT: 1 if signed(A) < signed(B), else 0, zero-extended.
- 4 SLTU: 1 if unsigned(A) < unsigned(B), else 0.
- 5 XOR: A ^ B.
- 6 SRL: A >> B[4:0], zero fill.
- 7 SRA: A >>> B[4:0], sign fill from A[W−1].
- 8 OR: A | B.
- 9 AND: A & B.
- 10 PASSB: B (used for LUI).
- 11–15: result 0, no error signalled.

Arithmetic and shift rules:
- Shift amount is B[log2(W)−1:0]; upper bits of B are ignored.
- A shift amount of 0 returns A unchanged.
- Overflow is silent: 0x7FFFFFFF+1 = 0x80000000; 0−1 = 0xFFFFFFFF.
- SLT with the most-negative value: 0x80000000 < 0x00000000 gives 1. SLTU for the same pair gives 0.
- All comparisons are strict; equal operands give 0.

## Timing
- Combinational compute from `A`, `B`, `ALUSel`; registered into `result` on every rising `clk` edge. There is no enable and no handshake.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on `result` after edge N and hold until edge N+1.
- Reset: `rst_n` low forces `result` = 0 (and `zero` = 1 when built) immediately, without waiting for a clock edge.
- Reset deassertion is synchronized by the system. The first valid capture is the first rising edge with `rst_n` high.
- Reset asserted mid-stream discards the in-flight result. There are no partial or stale values after release.
- Inputs changing between edges have no effect on the outputs until the next edge.

## Configuration
- `ALU_ZERO_FLAG_EN` defined: adds the `zero` output.
  - `zero` is registered alongside `result`: 1 when the next-state result equals 0.
  - It is the branch-compare assist: SUB with A == B gives `zero` = 1.
  - Reset value is 1.
- Macro undefined: the `zero` port and its flop do not exist. `result` behaviour is identical in both builds.

## Structure
- Shared package `rv32i_pkg` holds:
  - the `OPERANDS_WIDTH` (32) and `ALU_SEL_WIDTH` (4) constants;
  - the `alu_op_t` enumeration with the 11 encodings above;
  - the shift-amount width constant (5).
- One sub-module, `alu_shifter`:
  - a combinational log-stage barrel shifter covering SLL/SRL/SRA;
  - inputs: data, amount, direction, arithmetic flag.
- The top holds the adder/subtractor (shared, with SLT/SLTU derived from the subtract path), the logic ops, the output mux and the output register.

## Test plan
- Reset: hold `rst_n` low with arbitrary inputs → `result` = 0 asynchronously (`zero` = 1 if built). The first edge after release captures the current op.
- Arithmetic:
  - A=0, B=5, ADD → 5 one cycle later.
  - A=40, B=−50, SUB → 90 (0x5A).
  - A=0x7FFFFFFF, B=1, ADD → 0x80000000.
- Compares:
  - A=−5, B=10, SLT → 1.
  - Same operands, SLTU → 0.
  - A=B=7, SLT → 0.
- Shifts:
  - A=−4, B=1, SRA → 0xFFFFFFFE.
  - A=0x80000000, B=31, SRL → 1.
  - A=1, B=0x25 (only the low 5 bits, 5, are used), SLL → 0x20.
- Logic and unused codes:
  - A=0xF0F0F0F0, B=0x0FF00FF0: XOR → 0xFF00FF00; OR → 0xFFF0FFF0; AND → 0x00F000F0.
  - PASSB → B.
  - `ALUSel`=13 → 0.
- Back-to-back and mid-stream reset: change op every cycle and check each `result` lags its inputs by exactly one edge. Assert reset mid-stream → `result` clears immediately.
